// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-bit slice per clock, LSD first, with a start/busy/done handshake.
// Optional subtraction (A-B) is enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_co;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; the final carry then reads as "no borrow".
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub | ci;
`else
    logic w_unused_sub;
    assign w_b_in       = b;
    assign w_c_in       = ci;
    assign w_unused_sub = sub;
`endif

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};

    generate
        if (N == 1) begin : g_single
            logic w_unused_res;
            assign w_res_next   = w_dsum[DIGIT-1:0];
            assign w_a_next     = '0;
            assign w_b_next     = '0;
            assign w_unused_res = ^r_res;
        end else begin : g_multi
            // New digit enters at the top; after N shifts the first digit sits at bit 0.
            assign w_res_next = {w_dsum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
            assign w_a_next   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
            assign w_b_next   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_next;
                    r_b     <= w_b_next;
                    r_res   <= w_res_next;
                    r_carry <= w_dsum[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_sum   <= w_res_next;
                        r_co    <= w_dsum[DIGIT];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: 32/4 main instance plus WIDTH=8 sweep instances (DIGIT=1/2/8).
module tb_digit_serial_adder;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ci = 1'b0;
    logic        sub = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        co;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ci8 = 1'b0;
    logic        s_busy [3];
    logic        s_done [3];
    logic [7:0]  s_sum  [3];
    logic        s_co   [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .co(co)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sweep
            localparam int DG = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);
            digit_serial_adder #(.WIDTH(8), .DIGIT(DG)) u_w8 (
                .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8), .sub(1'b0),
                .busy(s_busy[gi]), .done(s_done[gi]), .sum(s_sum[gi]), .co(s_co[gi])
            );
        end
    endgenerate

    // Reference: {co,sum} = a+b+ci, or (a-b, a>=b) when subtraction is enabled and requested.
    function automatic logic [32:0] ref_op(input logic [31:0] ia, input logic [31:0] ib,
                                           input logic ici, input logic isub);
        if (isub && SUB_EN) return {(ia >= ib), ia - ib};
        return {1'b0, ia} + {1'b0, ib} + {32'b0, ici};
    endfunction

    // Launch one operation from idle and follow it until busy falls (bounded).
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                         input logic isub, input bit poke, output int busy_cyc,
                         output bit got_done, output bit sum_moved);
        logic [31:0] sum0;
        logic        co0;
        a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
        sum0 = sum; co0 = co;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
        busy_cyc = 0;
        sum_moved = 1'b0;
        while (busy === 1'b1 && busy_cyc < 100) begin
            if (sum !== sum0 || co !== co0 || done !== 1'b0) sum_moved = 1'b1;
            start = (poke && busy_cyc == 2);
            @(posedge clk); #1;
            busy_cyc++;
        end
        start = 1'b0;
        got_done = (done === 1'b1);
    endtask

    task automatic check_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                            input logic ici, input logic isub, input bit poke);
        int          bc;
        bit          gd;
        bit          mv;
        logic [32:0] exp;
        exp = ref_op(ia, ib, ici, isub);
        do_op(ia, ib, ici, isub, poke, bc, gd, mv);
        n_checks++;
        if (bc != 8) $display("FAIL %s busy_cycles: got %0d want 8", name, bc);
        else n_pass++;
        n_checks++;
        if (!gd || mv) $display("FAIL %s done/stable: got done=%0b moved=%0b want done=1 moved=0", name, gd, mv);
        else n_pass++;
        n_checks++;
        if ({co, sum} !== exp) $display("FAIL %s result: got co=%0b sum=%h want co=%0b sum=%h", name, co, sum, exp[32], exp[31:0]);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {co, sum} !== exp)
            $display("FAIL %s after_done: got done=%0b busy=%0b sum=%h want 0 0 %h", name, done, busy, sum, exp[31:0]);
        else n_pass++;
        $display("op %s a=%h b=%h ci=%0b sub=%0b -> co=%0b sum=%h", name, ia, ib, ici, isub, co, sum);
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, co, sum} !== 35'd0) $display("FAIL reset_state: got busy=%0b done=%0b co=%0b sum=%h want zeros", busy, done, co, sum);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_op("pre_reset", 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0);
        a = 32'h0000_00FF; b = 32'h0000_0F00; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, co, sum} !== 35'd0) $display("FAIL reset_async: got busy=%0b done=%0b co=%0b sum=%h want zeros", busy, done, co, sum);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || sum !== 32'd0) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL reset_abort: got activity after release want none");
        else n_pass++;
        $display("reset test complete");
    endtask

    task automatic test_carry_ripple();
        check_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({co, sum} !== 33'h1_0000_0000) $display("FAIL ripple_const: got co=%0b sum=%h want co=1 sum=00000000", co, sum);
        else n_pass++;
    endtask

    task automatic test_carry_in_ignore_start();
        bit extra;
        check_op("carry_in_poke", 32'h12345678, 32'h0FEDCBA8, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({co, sum} !== {1'b0, 32'h22222221}) $display("FAIL carry_in_const: got co=%0b sum=%h want co=0 sum=22222221", co, sum);
        else n_pass++;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || sum !== 32'h22222221) extra = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra) $display("FAIL ignored_start: got extra activity want none");
        else n_pass++;
    endtask

    task automatic test_sub();
        check_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (SUB_EN && {co, sum} !== {1'b0, 32'hFFFFFFFE}) $display("FAIL sub_5_7_const: got co=%0b sum=%h want co=0 sum=fffffffe", co, sum);
        else if (!SUB_EN && {co, sum} !== {1'b0, 32'd12}) $display("FAIL add_5_7_const: got co=%0b sum=%h want co=0 sum=0000000c", co, sum);
        else n_pass++;
        check_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
        check_op("sub_eq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            check_op($sformatf("rand%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [32:0] q_exp[$];
        logic [32:0] exp;
        logic [31:0] prev_sum;
        logic        prev_co;
        bit          moved;
        @(posedge clk); #1;
        prev_sum = sum; prev_co = co;
        moved = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 45; c++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
            if (c % 9 == 0) q_exp.push_back(ref_op(a, b, ci, sub));
            @(posedge clk); #1;
            if (c == 44) start = 1'b0;
            n_checks++;
            if (done !== (c % 9 == 8)) $display("FAIL b2b_done c=%0d: got %0b want %0b", c, done, (c % 9 == 8));
            else n_pass++;
            if (c % 9 == 8) begin
                exp = (q_exp.size() > 0) ? q_exp.pop_front() : 33'd0;
                n_checks++;
                if ({co, sum} !== exp) $display("FAIL b2b_result c=%0d: got co=%0b sum=%h want co=%0b sum=%h", c, co, sum, exp[32], exp[31:0]);
                else n_pass++;
                $display("b2b done c=%0d co=%0b sum=%h", c, co, sum);
                prev_sum = sum; prev_co = co;
            end else if (sum !== prev_sum || co !== prev_co) begin
                moved = 1'b1;
            end
        end
        n_checks++;
        if (moved) $display("FAIL b2b_stable: got sum change between done pulses want stable");
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        int          lat[3];
        logic [8:0]  res[3];
        logic [8:0]  exp;
        int          want_lat[3];
        want_lat = '{8, 4, 1};
        a8 = 8'hAA; b8 = 8'h56; ci8 = 1'b0;
        exp = {1'b0, a8} + {1'b0, b8} + {8'b0, ci8};
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0;
            res[k] = '0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (s_done[k] === 1'b1 && lat[k] == 0) begin
                    lat[k] = cyc;
                    res[k] = {s_co[k], s_sum[k]};
                end
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (lat[k] != want_lat[k]) $display("FAIL sweep%0d_latency: got %0d want %0d", k, lat[k], want_lat[k]);
            else n_pass++;
            n_checks++;
            if (res[k] !== exp) $display("FAIL sweep%0d_result: got %h want %h", k, res[k], exp);
            else n_pass++;
            $display("sweep inst %0d latency=%0d result=%h", k, lat[k], res[k]);
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_carry_in_ignore_start();
        test_sub();
        test_random();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
